// File: rtl/digit_scan_if.sv
// Scan bus between a display controller client and the digit scan sequencer.
// The master side drives enable and mask. The slave side returns the digit select, enables and pulses.
interface digit_scan_if;
   logic       i_en;
   logic [3:0] i_digit_mask;
   logic [1:0] o_addr;
   logic [3:0] o_an;
   logic       o_tick;
   logic       o_frame;

   modport master (
      output i_en,
      output i_digit_mask,
      input  o_addr,
      input  o_an,
      input  o_tick,
      input  o_frame
   );

   modport slave (
      input  i_en,
      input  i_digit_mask,
      output o_addr,
      output o_an,
      output o_tick,
      output o_frame
   );
endinterface

// File: rtl/digit_scan_ctrl.sv
// Four-digit time-multiplexed scan sequencer.
// Each slot starts with a dead-time blank and then drives the selected digit (active-low enables).
//
// state | meaning
// IDLE  | display off, position held, waiting for enable
// BLANK | all digits dark while the downstream mux settles on r_addr
// DRIVE | selected digit lit if its mask bit is set
module digit_scan_ctrl #(
   parameter int DIV   = 50000,
   parameter int BLANK = 500,
   parameter int CW    = 16
) (
   input  logic        i_clk,
   input  logic        i_rst,
   digit_scan_if.slave scan_if
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BLANK = 2'd1,
      S_DRIVE = 2'd2
   } state_t;

   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
   localparam logic [CW-1:0] DRIVE_LAST = CW'(DIV - BLANK - 1);

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [1:0]    r_addr;
   logic [3:0]    r_an;
   logic          r_tick;
   logic          r_frame;

   logic [3:0]    w_onehot;
   logic [3:0]    w_an_lit;

   assign w_onehot = 4'b0001 << r_addr;
   assign w_an_lit = ~(w_onehot & scan_if.i_digit_mask);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_addr  <= 2'd0;
         r_an    <= 4'b1111;
         r_tick  <= 1'b0;
         r_frame <= 1'b0;
      end else begin
         r_tick  <= 1'b0;
         r_frame <= 1'b0;
         if (!scan_if.i_en) begin
            // Disable wins in every state; r_addr is kept so scanning resumes at the same digit.
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_an    <= 4'b1111;
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_state <= S_BLANK;
                  r_cnt   <= '0;
                  r_an    <= 4'b1111;
               end
               S_BLANK: begin
                  if (r_cnt == BLANK_LAST) begin
                     r_state <= S_DRIVE;
                     r_cnt   <= '0;
                     r_an    <= w_an_lit;
                  end else begin
                     r_cnt   <= r_cnt + CW'(1);
                     r_an    <= 4'b1111;
                  end
               end
               S_DRIVE: begin
                  if (r_cnt == DRIVE_LAST) begin
                     r_state <= S_BLANK;
                     r_cnt   <= '0;
                     r_an    <= 4'b1111;
                     r_addr  <= r_addr + 2'd1;
                     r_tick  <= 1'b1;
                     r_frame <= (r_addr == 2'd3);
                  end else begin
                     r_cnt   <= r_cnt + CW'(1);
                     r_an    <= w_an_lit;
                  end
               end
               default: begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
                  r_an    <= 4'b1111;
               end
            endcase
         end
      end
   end

   assign scan_if.o_addr  = r_addr;
   assign scan_if.o_an    = r_an;
   assign scan_if.o_tick  = r_tick;
   assign scan_if.o_frame = r_frame;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Scoreboard bench for digit_scan_ctrl.
// A slot-position reference model queues the expected outputs per edge, and a monitor pops and compares them.
module tb_digit_scan_ctrl;
   localparam int DIV   = 8;
   localparam int BLANK = 2;
   localparam int CW    = 16;

   typedef struct {
      logic [3:0] an;
      logic [1:0] addr;
      logic       tick;
      logic       frame;
      bit         win;
   } exp_t;

   logic clk;
   logic rst;
   digit_scan_if bus ();

   digit_scan_ctrl #(.DIV(DIV), .BLANK(BLANK), .CW(CW)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .scan_if (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   // Reference model: running flag, position within the DIV-cycle slot, current digit.
   bit   m_run   = 1'b0;
   int   m_phase = 0;
   int   m_addr  = 0;
   bit   win     = 1'b0;

   int   dut_ticks = 0, dut_frames = 0, exp_ticks = 0, exp_frames = 0;

   task automatic step(input bit r, input bit e, input logic [3:0] m);
      exp_t ex;
      bit tk, fr;
      @(negedge clk);
      rst = r;
      bus.i_en = e;
      bus.i_digit_mask = m;
      tk = 1'b0;
      fr = 1'b0;
      if (r) begin
         m_run  = 1'b0;
         m_addr = 0;
         ex.an  = 4'b1111;
      end else if (!e) begin
         m_run  = 1'b0;
         ex.an  = 4'b1111;
      end else begin
         if (!m_run) begin
            m_run   = 1'b1;
            m_phase = 0;
         end else begin
            m_phase++;
            if (m_phase == DIV) begin
               m_phase = 0;
               fr      = (m_addr == 3);
               m_addr  = (m_addr + 1) % 4;
               tk      = 1'b1;
            end
         end
         if (m_phase < BLANK) ex.an = 4'b1111;
         else                 ex.an = ~(4'(1 << m_addr) & m);
      end
      ex.addr  = 2'(m_addr);
      ex.tick  = tk;
      ex.frame = fr;
      ex.win   = win;
      exp_q.push_back(ex);
   endtask

   // Monitor: one expected entry per edge once stimulus has started.
   initial begin
      exp_t ex;
      logic [1:0] prev_addr;
      bit have_prev;
      have_prev = 1'b0;
      prev_addr = 2'd0;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            ex = exp_q.pop_front();
            cyc++;
            checks++;
            if (bus.o_an !== ex.an || bus.o_addr !== ex.addr ||
                bus.o_tick !== ex.tick || bus.o_frame !== ex.frame) begin
               errors++;
               $display("FAIL scan_out cyc %0d: got an=%b addr=%0d tick=%b frame=%b, want an=%b addr=%0d tick=%b frame=%b",
                        cyc, bus.o_an, bus.o_addr, bus.o_tick, bus.o_frame,
                        ex.an, ex.addr, ex.tick, ex.frame);
            end
            if (have_prev && bus.o_an !== 4'b1111) begin
               checks++;
               if (bus.o_addr !== prev_addr) begin
                  errors++;
                  $display("FAIL addr_stable cyc %0d: addr moved %0d -> %0d while an=%b",
                           cyc, prev_addr, bus.o_addr, bus.o_an);
               end
            end
            prev_addr = bus.o_addr;
            have_prev = 1'b1;
            if (ex.win) begin
               dut_ticks  += int'(bus.o_tick);
               dut_frames += int'(bus.o_frame);
               exp_ticks  += int'(ex.tick);
               exp_frames += int'(ex.frame);
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      bus.i_en = 1'b1;
      bus.i_digit_mask = 4'b1111;

      // Reset with enable asserted
      repeat (3) step(1'b1, 1'b1, 4'b1111);

      // Full scan, all digits enabled
      repeat (80) step(1'b0, 1'b1, 4'b1111);

      // Partial mask, then unmask mid-DRIVE on digit 1
      repeat (40) step(1'b0, 1'b1, 4'b0101);
      for (int i = 0; i < 64 && !(m_run && m_addr == 1 && m_phase >= BLANK + 1); i++)
         step(1'b0, 1'b1, 4'b0101);
      repeat (12) step(1'b0, 1'b1, 4'b1111);

      // Disable during DRIVE on digit 2, then resume
      for (int i = 0; i < 64 && !(m_run && m_addr == 2 && m_phase >= BLANK + 1); i++)
         step(1'b0, 1'b1, 4'b1111);
      repeat (3) step(1'b0, 1'b0, 4'b1111);
      repeat (12) step(1'b0, 1'b1, 4'b1111);

      // Reset during DRIVE on digit 3, enable held
      for (int i = 0; i < 64 && !(m_run && m_addr == 3 && m_phase >= BLANK + 1); i++)
         step(1'b0, 1'b1, 4'b1111);
      step(1'b1, 1'b1, 4'b1111);
      repeat (40) step(1'b0, 1'b1, 4'b1111);

      // Long steady run with random mask changes; tick/frame cadence counted here
      win = 1'b1;
      for (int i = 0; i < 1024; i++)
         step(1'b0, 1'b1, ($urandom_range(0, 15) == 0) ? 4'($urandom) : bus.i_digit_mask);
      win = 1'b0;

      // Random enable/reset/mask interference, including an all-masked stretch
      repeat (64) step(1'b0, 1'b1, 4'b0000);
      for (int i = 0; i < 400; i++)
         step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) != 0), 4'($urandom));

      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
      end
      checks++;
      if (dut_ticks != exp_ticks || exp_ticks != 1024 / DIV) begin
         errors++;
         $display("FAIL tick_count: got %0d, want %0d", dut_ticks, 1024 / DIV);
      end
      checks++;
      if (dut_frames != exp_frames || exp_frames != 1024 / (4 * DIV)) begin
         errors++;
         $display("FAIL frame_count: got %0d, want %0d", dut_frames, 1024 / (4 * DIV));
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
